// File: rtl/playlist_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// playlist_ctrl : playback sequencer (play/pause, skip, auto-advance, repeat)
// Rev 1.0
// ---------------------------------------------------------------------------
module playlist_ctrl #(
  parameter int NUM_SONGS  = 4,
  parameter int SONG_W     = 2,
  parameter int RST_HOLD   = 2,
  parameter int DONE_GUARD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_btn,
  input  logic              next_btn,
  input  logic              prev_btn,
  input  logic              repeat_one,
  input  logic              loop_all,
  input  logic              song_done,
  output logic              play,
  output logic              pause,
  output logic              reset_player,
  output logic [SONG_W-1:0] song,
  output logic [1:0]        status,
  output logic              song_changed
);

  localparam int GUARD_W = $clog2(DONE_GUARD + 2);
  localparam int HOLD_W  = $clog2(RST_HOLD + 1);
  localparam logic [SONG_W-1:0]  LAST_SONG  = SONG_W'(NUM_SONGS - 1);
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(DONE_GUARD);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(RST_HOLD - 1);

  // State encoding doubles as the status code.
  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_SKIP  = 2'b11
  } state_t;

  state_t               state;
  logic [GUARD_W-1:0]   guard;
  logic [HOLD_W-1:0]    skip_cnt;
  logic                 resume_paused;
  logic [SONG_W-1:0]    song_next;
  logic [SONG_W-1:0]    song_prev;

  assign song_next = (song == LAST_SONG) ? '0 : song + SONG_W'(1);
  assign song_prev = (song == '0) ? LAST_SONG : song - SONG_W'(1);
  assign status    = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_STOP;
      song          <= '0;
      play          <= 1'b0;
      pause         <= 1'b0;
      reset_player  <= 1'b1;
      song_changed  <= 1'b0;
      guard         <= '0;
      skip_cnt      <= '0;
      resume_paused <= 1'b0;
    end else begin
      song_changed <= 1'b0;
      case (state)
        ST_STOP: begin
          reset_player <= 1'b0;
          if (next_btn) begin
            song         <= song_next;
            song_changed <= 1'b1;
          end else if (prev_btn) begin
            song         <= song_prev;
            song_changed <= 1'b1;
          end else if (play_btn) begin
            state <= ST_PLAY;
            play  <= 1'b1;
            pause <= 1'b0;
            guard <= GUARD_LOAD;
          end
        end

        ST_PLAY, ST_PAUSE: begin
          if (state == ST_PLAY && guard != '0)
            guard <= guard - GUARD_W'(1);
          if (next_btn || prev_btn) begin
            song          <= next_btn ? song_next : song_prev;
            song_changed  <= 1'b1;
            state         <= ST_SKIP;
            play          <= 1'b0;
            pause         <= 1'b0;
            reset_player  <= 1'b1;
            skip_cnt      <= HOLD_LOAD;
            resume_paused <= (state == ST_PAUSE);
          end else if (play_btn) begin
            state <= (state == ST_PAUSE) ? ST_PLAY : ST_PAUSE;
            pause <= (state == ST_PLAY);
          end else if (song_done && state == ST_PLAY && guard == '0) begin
            resume_paused <= 1'b0;
            // Last song without loop_all stops; every other case restarts the reader.
            if (!repeat_one && song == LAST_SONG && !loop_all) begin
              song         <= '0;
              song_changed <= 1'b1;
              state        <= ST_STOP;
              play         <= 1'b0;
              pause        <= 1'b0;
            end else begin
              if (!repeat_one) begin
                song         <= song_next;
                song_changed <= 1'b1;
              end
              state        <= ST_SKIP;
              play         <= 1'b0;
              pause        <= 1'b0;
              reset_player <= 1'b1;
              skip_cnt     <= HOLD_LOAD;
            end
          end
        end

        ST_SKIP: begin
          if (skip_cnt == '0) begin
            state        <= resume_paused ? ST_PAUSE : ST_PLAY;
            play         <= 1'b1;
            pause        <= resume_paused;
            reset_player <= 1'b0;
            guard        <= GUARD_LOAD;
          end else begin
            skip_cnt <= skip_cnt - HOLD_W'(1);
          end
        end

        default: state <= ST_STOP;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_playlist_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_playlist_ctrl : directed + randomized bench against a behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_playlist_ctrl;

  localparam int N    = 4;
  localparam int SW   = 2;
  localparam int HOLD = 2;
  localparam int G    = 4;

  localparam int M_STOP  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_SKIP  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          play_btn = 1'b0, next_btn = 1'b0, prev_btn = 1'b0;
  logic          repeat_one = 1'b0, loop_all = 1'b0, song_done = 1'b0;
  logic          play, pause, reset_player, song_changed;
  logic [SW-1:0] song;
  logic [1:0]    status;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m_mode = M_STOP, m_song = 0, m_guard = 0, m_left = 0;
  bit m_resume = 1'b0, m_changed = 1'b0, m_after_rst = 1'b1;

  always #5 clk = ~clk;

  playlist_ctrl #(.NUM_SONGS(N), .SONG_W(SW), .RST_HOLD(HOLD), .DONE_GUARD(G)) dut (
    .clk(clk), .reset(reset), .play_btn(play_btn), .next_btn(next_btn),
    .prev_btn(prev_btn), .repeat_one(repeat_one), .loop_all(loop_all),
    .song_done(song_done), .play(play), .pause(pause),
    .reset_player(reset_player), .song(song), .status(status),
    .song_changed(song_changed)
  );

  task automatic cmp(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic enter_skip(bit res);
    m_mode   = M_SKIP;
    m_left   = HOLD;
    m_resume = res;
  endtask

  // Reference behaviour: one event per cycle, song arithmetic modulo N.
  task automatic model_step();
    int g0;
    bit was_pause;
    m_changed   = 1'b0;
    m_after_rst = 1'b0;
    case (m_mode)
      M_STOP: begin
        if (next_btn) begin m_song = (m_song + 1) % N; m_changed = 1'b1; end
        else if (prev_btn) begin m_song = (m_song + N - 1) % N; m_changed = 1'b1; end
        else if (play_btn) begin m_mode = M_PLAY; m_guard = G; end
      end
      M_PLAY, M_PAUSE: begin
        was_pause = (m_mode == M_PAUSE);
        g0 = m_guard;
        if (!was_pause && m_guard > 0) m_guard--;
        if (next_btn) begin
          m_song = (m_song + 1) % N; m_changed = 1'b1; enter_skip(was_pause);
        end else if (prev_btn) begin
          m_song = (m_song + N - 1) % N; m_changed = 1'b1; enter_skip(was_pause);
        end else if (play_btn) begin
          m_mode = was_pause ? M_PLAY : M_PAUSE;
        end else if (song_done && !was_pause && g0 == 0) begin
          if (repeat_one) enter_skip(1'b0);
          else if (m_song < N - 1) begin m_song++; m_changed = 1'b1; enter_skip(1'b0); end
          else begin
            m_song = 0; m_changed = 1'b1;
            if (loop_all) enter_skip(1'b0);
            else m_mode = M_STOP;
          end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_mode  = m_resume ? M_PAUSE : M_PLAY;
          m_guard = G;
        end
      end
    endcase
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_STOP; m_song = 0; m_guard = 0; m_left = 0;
      m_resume = 1'b0; m_changed = 1'b0; m_after_rst = 1'b1;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("play", play, (m_mode == M_PLAY || m_mode == M_PAUSE));
      cmp("pause", pause, (m_mode == M_PAUSE));
      cmp("reset_player", reset_player, (m_after_rst || m_mode == M_SKIP));
      cmp("song", song, m_song);
      cmp("status", status, m_mode);
      cmp("song_changed", song_changed, m_changed);
    end
  end

  task automatic step(bit p, bit n, bit pr, bit d);
    play_btn = p; next_btn = n; prev_btn = pr; song_done = d;
    @(posedge clk);
    @(negedge clk);
    play_btn = 1'b0; next_btn = 1'b0; prev_btn = 1'b0; song_done = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    cmp("lit_rst_rp", reset_player, 1);
    cmp("lit_rst_status", status, 0);
    cmp("lit_rst_song", song, 0);
    idle(1);
    cmp("lit_rp_released", reset_player, 0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    cmp("lit_play_on", play, 1);
    cmp("lit_play_status", status, 1);
    cmp("lit_play_song", song, 0);

    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    cmp("lit_guard_status", status, 1);
    cmp("lit_guard_song", song, 0);
    cmp("lit_guard_chg", song_changed, 0);

    idle(4);
    repeat_one = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    cmp("lit_rep_status", status, 3);
    cmp("lit_rep_song", song, 0);
    cmp("lit_rep_chg", song_changed, 0);
    cmp("lit_rep_rp", reset_player, 1);
    idle(1);
    cmp("lit_rep_rp2", reset_player, 1);
    idle(1);
    cmp("lit_rep_back", status, 1);
    cmp("lit_rep_rp_off", reset_player, 0);
    repeat_one = 1'b0;

    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2 + 5);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    cmp("lit_nd_song", song, 2);
    cmp("lit_nd_status", status, 3);
    cmp("lit_nd_chg", song_changed, 1);
    idle(2);

    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    cmp("lit_paused", status, 2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    cmp("lit_pn_song", song, 2);
    cmp("lit_pn_rp", reset_player, 1);
    idle(1);
    cmp("lit_pn_rp2", reset_player, 1);
    idle(1);
    cmp("lit_pn_status", status, 2);
    cmp("lit_pn_pause", pause, 1);
    cmp("lit_pn_play", play, 1);
    cmp("lit_pn_rp_off", reset_player, 0);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2 + 5);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    cmp("lit_end_song", song, 0);
    cmp("lit_end_status", status, 0);
    cmp("lit_end_play", play, 0);
    cmp("lit_end_chg", song_changed, 1);
    idle(1);
    cmp("lit_end_chg_once", song_changed, 0);

    step(1'b0, 1'b0, 1'b1, 1'b0);
    cmp("lit_prev_wrap", song, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    loop_all = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    cmp("lit_loop_song", song, 0);
    cmp("lit_loop_status", status, 3);
    idle(1);
    cmp("lit_loop_status2", status, 3);
    idle(1);
    cmp("lit_loop_play", status, 1);
    loop_all = 1'b0;

    step(1'b0, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    cmp("lit_async_status", status, 0);
    cmp("lit_async_rp", reset_player, 1);
    cmp("lit_async_play", play, 0);
    cmp("lit_async_song", song, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    idle(1);
    cmp("lit_post_status", status, 0);
    cmp("lit_post_song", song, 0);
    cmp("lit_post_rp", reset_player, 0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) repeat_one = ~repeat_one;
      if ($urandom_range(0, 49) == 0) loop_all = ~loop_all;
      step($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 4) == 0);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/playlist_ctrl.md
Name: playlist_ctrl

Overview:
Top-level playback sequencer for the music player. It turns debounced one-cycle button pulses and the reader's song_done pulse into the play/song controls for the song reader, a pause freeze for the note player, and a restart pulse for the reader. It handles play/pause, next/prev, auto-advance, end-of-playlist and repeat modes.

Parameters:
NUM_SONGS, 4, number of songs in ROM (>=2)
SONG_W, 2, width of song index (2**SONG_W >= NUM_SONGS)
RST_HOLD, 2, cycles reset_player is held high during a skip (>=1)
DONE_GUARD, 4, cycles after (re)start during which song_done is ignored

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
play_btn  input  1  one-cycle pulse, toggle play/pause
next_btn  input  1  one-cycle pulse, skip forward
prev_btn  input  1  one-cycle pulse, skip back
repeat_one  input  1  level, loop the current song
loop_all  input  1  level, wrap from last song to song 0 and keep playing
song_done  input  1  one-cycle pulse from song reader
play  output  1  level to song reader play input
pause  output  1  level, freezes note player/duration counter
reset_player  output  1  synchronous restart to song reader, active high
song  output  SONG_W  current song index to song reader
status  output  2  00 stopped, 01 playing, 10 paused, 11 skipping
song_changed  output  1  one-cycle pulse when song index is updated

Behaviour:
- reset low (async): state STOP, song=0, play=0, pause=0, reset_player=1, song_changed=0, guard counter=0, resume_paused=0. On the first clk after release, reset_player=0.
- All outputs are registered. Transitions take 1 cycle after the input pulse.
- STOP: play=0, pause=0.
  - play_btn: go to PLAY and load guard=DONE_GUARD.
  - next_btn/prev_btn: song +/-1 modulo NUM_SONGS, pulse song_changed, stay in STOP.
- PLAY: play=1, pause=0. The guard decrements to 0. song_done is honoured only when guard==0.
- PAUSE: play=1 (the reader keeps its position), pause=1.
  - play_btn: go to PLAY. The guard is not reloaded.
- SKIP: play=0, reset_player=1 for exactly RST_HOLD cycles.
  - Then go to PLAY, or to PAUSE if resume_paused=1, and load guard=DONE_GUARD.
  - Button pulses and song_done are ignored while in SKIP.
- Event priority in PLAY/PAUSE, one event per cycle: next_btn > prev_btn > play_btn > song_done. Lower-priority events in the same cycle are dropped.
- next_btn (PLAY/PAUSE): song = song+1; wrap NUM_SONGS-1 to 0 regardless of loop_all. Go to SKIP, set resume_paused = (state==PAUSE), pulse song_changed.
- prev_btn (PLAY/PAUSE): song = song-1; wrap 0 to NUM_SONGS-1. Otherwise as next_btn.
- play_btn: PLAY goes to PAUSE; PAUSE goes to PLAY.
- song_done in PLAY with guard==0:
  - repeat_one=1: song unchanged, go to SKIP, no song_changed.
  - else if song<NUM_SONGS-1: song+1, go to SKIP, pulse song_changed.
  - else if loop_all=1: song=0, go to SKIP, pulse song_changed.
  - else: song=0, go to STOP, pulse song_changed.
- song_done in PAUSE or STOP is ignored.
- Song index arithmetic is modulo NUM_SONGS, not modulo 2**SONG_W. An index >= NUM_SONGS is never produced.
- Reset asserted mid-SKIP or mid-PAUSE returns to the reset values immediately. No pending event survives reset.
- status encodes the current state exactly. SKIP status is held for RST_HOLD cycles.

Test Plan:
- Reset, play_btn at cycle 5 -> play=1 at cycle 6, status=01, song=0; reset_player low from first post-reset edge.
- Playing song 3 (NUM_SONGS=4), loop_all=0, song_done after guard -> song=0, play=0, status=00, one song_changed pulse. Repeat with loop_all=1 -> status=11 for 2 cycles, then 01, song=0.
- Paused on song 1, next_btn -> song=2, reset_player high exactly 2 cycles, then status=10 with pause=1, play=1.
- song_done 2 cycles after entering PLAY (inside the guard) -> ignored, song unchanged. song_done at guard==0 with repeat_one=1 -> SKIP with song unchanged, no song_changed.
- next_btn and song_done in the same cycle on song 1 -> song=2 only (a single increment). prev_btn on song 0 -> song=3.
- reset pulsed low during SKIP cycle 1 -> outputs at reset values asynchronously, status=00 after release, song=0.
